// File: rtl/line_xfer_pkg.sv
// Shared types and constants for the cache-side line transfer controller.
package line_xfer_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS_PER_LINE = 8;
  localparam int unsigned LINE_W         = WORD_W * WORDS_PER_LINE;
  localparam int unsigned BEAT_W         = 3;
  localparam int unsigned OFFSET_W       = 5;
  localparam int unsigned LINE_ADDR_W    = ADDR_W - OFFSET_W;
  localparam int unsigned WORD_IDX_W     = $clog2(WORD_W);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } xfer_state_t;

  typedef enum logic {
    REQ_DC = 1'b0,
    REQ_IC = 1'b1
  } req_id_t;

  // The requester that is not 'id'.
  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_DC) ? REQ_IC : REQ_DC;
  endfunction

endpackage

// File: rtl/line_arbiter.sv
// Two-requester grant logic for line_xfer_ctrl.
// Build option: LINE_XFER_RR_ARB_EN selects round-robin tie breaking;
// without it DC always wins a tie.
module line_arbiter
  import line_xfer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ic_req_i,
  input  logic dc_req_i,
  input  logic take_i,
  output logic gnt_valid_c,
  output logic gnt_ic_c
);

  // Favoured requester for the next tie; only contested grants move it.
  req_id_t ptr_q, ptr_d;

`ifdef LINE_XFER_RR_ARB_EN
  logic tie;
  assign tie = ic_req_i & dc_req_i;
`endif

  // Grant: a lone requester wins, a tie goes to the favoured requester.
  always_comb begin
    gnt_valid_c = take_i & (ic_req_i | dc_req_i);
    gnt_ic_c    = ic_req_i & (~dc_req_i | (ptr_q == REQ_IC));
  end

  // Tie-breaker update.
  always_comb begin
    ptr_d = ptr_q;
`ifdef LINE_XFER_RR_ARB_EN
    if (gnt_valid_c && tie) begin
      ptr_d = other_req(gnt_ic_c ? REQ_IC : REQ_DC);
    end
`endif
  end

  // Tie-breaker register, reset favouring DC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= REQ_DC;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/line_xfer_ctrl.sv
// Memory-side line transfer controller: arbitrates I-cache fills against
// D-cache fills/writebacks and runs one 8-beat burst per grant through an
// internal line buffer.
// Build option: LINE_XFER_RR_ARB_EN (round-robin arbitration, in line_arbiter).
module line_xfer_ctrl
  import line_xfer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ic_req,
  input  logic [ADDR_W-1:0]   ic_addr,
  output logic                ic_done,
  output logic [LINE_W-1:0]   ic_line,
  input  logic                dc_req,
  input  logic                dc_we,
  input  logic [ADDR_W-1:0]   dc_addr,
  input  logic [LINE_W-1:0]   dc_wline,
  output logic                dc_done,
  output logic [LINE_W-1:0]   dc_line,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [WORD_W-1:0]   mem_rdata,
  output logic                busy
);

  xfer_state_t             state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  req_id_t                 grant_q, grant_d;
  logic                    we_q, we_d;
  logic [LINE_ADDR_W-1:0]  line_addr_q, line_addr_d;
  logic [LINE_W-1:0]       buf_q, buf_d;
  logic [LINE_W-1:0]       ic_line_q, ic_line_d;
  logic [LINE_W-1:0]       dc_line_q, dc_line_d;

  logic                    gnt_valid_c;
  logic                    gnt_ic_c;
  logic [WORD_IDX_W+BEAT_W-1:0] word_lsb;
  logic                    unused_addr_bits;

  // Byte-offset bits of the request addresses do not select anything.
  assign unused_addr_bits = ^{ic_addr[OFFSET_W-1:0], dc_addr[OFFSET_W-1:0]};

  assign word_lsb = {beat_q, WORD_IDX_W'(0)};

  line_arbiter u_arb (
    .clk         (clk),
    .rst         (rst),
    .ic_req_i    (ic_req),
    .dc_req_i    (dc_req),
    .take_i      (state_q == IDLE),
    .gnt_valid_c (gnt_valid_c),
    .gnt_ic_c    (gnt_ic_c)
  );

  // Next state, beat sequencing and line buffer updates.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    grant_d     = grant_q;
    we_d        = we_q;
    line_addr_d = line_addr_q;
    buf_d       = buf_q;
    ic_line_d   = ic_line_q;
    dc_line_d   = dc_line_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid_c) begin
          beat_d  = '0;
          state_d = XFER;
          if (gnt_ic_c) begin
            grant_d     = REQ_IC;
            we_d        = 1'b0;
            line_addr_d = ic_addr[ADDR_W-1:OFFSET_W];
          end else begin
            grant_d     = REQ_DC;
            we_d        = dc_we;
            line_addr_d = dc_addr[ADDR_W-1:OFFSET_W];
            if (dc_we) begin
              buf_d = dc_wline;
            end
          end
        end
      end

      XFER: begin
        if (mem_ack) begin
          if (!we_q) begin
            buf_d[word_lsb +: WORD_W] = mem_rdata;
          end
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
            // Publish the line including the word arriving on this ack.
            if (!we_q) begin
              if (grant_q == REQ_IC) begin
                ic_line_d = buf_d;
              end else begin
                dc_line_d = buf_d;
              end
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      grant_q     <= REQ_DC;
      we_q        <= 1'b0;
      line_addr_q <= '0;
      buf_q       <= '0;
      ic_line_q   <= '0;
      dc_line_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      line_addr_q <= line_addr_d;
      buf_q       <= buf_d;
      ic_line_q   <= ic_line_d;
      dc_line_q   <= dc_line_d;
    end
  end

  // Port decode straight from registers; every output is zero while idle.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == XFER) begin
      mem_req  = 1'b1;
      mem_we   = we_q;
      mem_addr = {line_addr_q, beat_q, (OFFSET_W - BEAT_W)'(0)};
      if (we_q) begin
        mem_wdata = buf_q[word_lsb +: WORD_W];
      end
    end
  end

  assign ic_done = (state_q == DONE) && (grant_q == REQ_IC);
  assign dc_done = (state_q == DONE) && (grant_q == REQ_DC);
  assign busy    = (state_q != IDLE);
  assign ic_line = ic_line_q;
  assign dc_line = dc_line_q;

endmodule

// File: tb/tb_line_xfer_ctrl.sv
// Directed self-checking bench for line_xfer_ctrl.
module tb_line_xfer_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_req;
  logic [31:0]  ic_addr;
  logic         ic_done;
  logic [255:0] ic_line;
  logic         dc_req;
  logic         dc_we;
  logic [31:0]  dc_addr;
  logic [255:0] dc_wline;
  logic         dc_done;
  logic [255:0] dc_line;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         busy;

  logic [31:0]  rd_base;
  logic [255:0] exp_ic_line;
  logic [255:0] exp_dc_line;
  int           n_checks = 0;
  int           n_err    = 0;

  typedef struct {
    logic        is_dc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] base;
    int          stall_beat;
    int          stall_n;
    int          drop_beat;
    int          exp_cycle;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  // Memory model: read word = base + word index within the line.
  assign mem_rdata = rd_base + 32'(mem_addr[4:2]);

  line_xfer_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_done   (ic_done),
    .ic_line   (ic_line),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_wline  (dc_wline),
    .dc_done   (dc_done),
    .dc_line   (dc_line),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wline_word(input int k);
    return 32'h1111_0000 + 32'(k);
  endfunction

  // Called at the negedge on which the request is (or requests are) visible
  // in IDLE; follows one burst to its done pulse and one cycle beyond.
  task automatic run_xfer(input logic is_dc, input logic we, input logic [31:0] addr,
                          input logic [31:0] base, input int stall_beat, input int stall_n,
                          input int drop_beat, input int exp_cycle);
    int           n;
    int           beat;
    int           stall_left;
    bit           fin;
    logic [31:0]  exp_addr;
    logic [255:0] exp_line;
    rd_base    = base;
    n          = 1;
    beat       = 0;
    stall_left = stall_n;
    fin        = 0;
    exp_line   = '0;
    for (int c = 0; c < 64 && !fin; c++) begin
      @(negedge clk);
      n++;
      if (ic_done || dc_done) begin
        chk("done_id", {ic_done, dc_done}, is_dc ? 2'b01 : 2'b10);
        chk("done_cycle", n, exp_cycle);
        chk("beats_done", beat, 8);
        if (!we) begin
          for (int k = 0; k < 8; k++) exp_line[k*32 +: 32] = base + 32'(k);
          if (is_dc) exp_dc_line = exp_line;
          else       exp_ic_line = exp_line;
        end
        chk("ic_line", ic_line, exp_ic_line);
        chk("dc_line", dc_line, exp_dc_line);
        if (is_dc) dc_req = 1'b0;
        else       ic_req = 1'b0;
        @(negedge clk);
        chk("after_done", {ic_done, dc_done, busy}, 3'b000);
        fin = 1;
      end else if (mem_req) begin
        exp_addr = {addr[31:5], 3'(beat), 2'b00};
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_we", mem_we, we);
        if (we) chk("mem_wdata", mem_wdata, wline_word(beat));
        if (beat == drop_beat) begin
          if (is_dc) dc_req = 1'b0;
          else       ic_req = 1'b0;
        end
        if (beat == stall_beat && stall_left > 0) begin
          mem_ack = 1'b0;
          stall_left--;
        end else begin
          mem_ack = 1'b1;
          beat++;
        end
      end
    end
    if (!fin) begin
      n_checks++;
      n_err++;
      $display("FAIL timeout: no done after %0d cycles (beat %0d)", n, beat);
    end
    mem_ack = 1'b1;
  endtask

  task automatic start_req(input logic is_dc, input logic we, input logic [31:0] addr);
    if (is_dc) begin
      dc_req  = 1'b1;
      dc_we   = we;
      dc_addr = addr;
    end else begin
      ic_req  = 1'b1;
      ic_addr = addr;
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_1040, 32'h0000_00A0, -1, 0, -1, 10};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'h0000_0000,  3, 2, -1, 12};
    vecs[2] = '{1'b1, 1'b0, 32'h8000_0FFF, 32'h5500_0000, -1, 0, -1, 10};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_00C0,  7, 1, -1, 11};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_3000, 32'h0000_0B00, -1, 0,  2, 10};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_5020, 32'h0000_0000, -1, 0, -1, 10};

    rst      = 1'b1;
    ic_req   = 1'b0;
    ic_addr  = '0;
    dc_req   = 1'b0;
    dc_we    = 1'b0;
    dc_addr  = '0;
    mem_ack  = 1'b1;
    rd_base  = '0;
    for (int k = 0; k < 8; k++) dc_wline[k*32 +: 32] = wline_word(k);
    exp_ic_line = '0;
    exp_dc_line = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", {mem_req, mem_we, busy, ic_done, dc_done}, 5'b0);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_ic_line", ic_line, 256'h0);
    chk("reset_dc_line", dc_line, 256'h0);

    // Single-requester transfers.
    for (int i = 0; i < 6; i++) begin
      start_req(vecs[i].is_dc, vecs[i].we, vecs[i].addr);
      run_xfer(vecs[i].is_dc, vecs[i].we, vecs[i].addr, vecs[i].base,
               vecs[i].stall_beat, vecs[i].stall_n, vecs[i].drop_beat, vecs[i].exp_cycle);
    end

    // First tie: DC wins under either policy, IC follows with no loss.
    start_req(1'b1, 1'b0, 32'h0000_6000);
    start_req(1'b0, 1'b0, 32'h0000_7000);
    run_xfer(1'b1, 1'b0, 32'h0000_6000, 32'h0000_3000, -1, 0, -1, 10);
    run_xfer(1'b0, 1'b0, 32'h0000_7000, 32'h0000_4000, -1, 0, -1, 10);

    // Second tie: round-robin now favours IC, fixed priority keeps DC first.
    start_req(1'b1, 1'b0, 32'h0000_8000);
    start_req(1'b0, 1'b0, 32'h0000_9000);
`ifdef LINE_XFER_RR_ARB_EN
    run_xfer(1'b0, 1'b0, 32'h0000_9000, 32'h0000_7700, -1, 0, -1, 10);
    run_xfer(1'b1, 1'b0, 32'h0000_8000, 32'h0000_6600, -1, 0, -1, 10);
`else
    run_xfer(1'b1, 1'b0, 32'h0000_8000, 32'h0000_6600, -1, 0, -1, 10);
    run_xfer(1'b0, 1'b0, 32'h0000_9000, 32'h0000_7700, -1, 0, -1, 10);
`endif

    // Reset after the beat-4 ack abandons the burst.
    rd_base = 32'h0000_0D00;
    start_req(1'b0, 1'b0, 32'h0000_A000);
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", {busy, mem_req}, 2'b11);
    chk("pre_rst_addr", mem_addr, 32'h0000_A014);
    rst = 1'b1;
    #1;
    chk("rst_ctrl", {mem_req, busy, ic_done, dc_done}, 4'b0);
    chk("rst_ic_line", ic_line, 256'h0);
    chk("rst_dc_line", dc_line, 256'h0);
    exp_ic_line = '0;
    exp_dc_line = '0;
    ic_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {mem_req, busy, ic_done, dc_done}, 4'b0);
    start_req(1'b0, 1'b0, 32'h0000_B040);
    run_xfer(1'b0, 1'b0, 32'h0000_B040, 32'h0000_0E00, -1, 0, -1, 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/line_xfer_ctrl.md
Name: line_xfer_ctrl

Overview:
- Memory-side transfer controller for the cache subsystem.
- Arbitrates between I-cache line fills and D-cache line fills or writebacks, then sequences one 8-beat, 32-bit-word burst on the single memory port.
- Contains its own 256-bit line buffer: writebacks are serialized word 0 first; fills are assembled word-by-word into a 256-bit line.

Parameters:
- ADDR_W, 32, byte-address width.
- WORD_W, 32, memory word width.
- WORDS_PER_LINE, 8, beats per line; must be a power of 2. LINE_W = WORD_W*WORDS_PER_LINE = 256.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ic_req  in  1  I-cache fill request; held until ic_done.
- ic_addr  in  ADDR_W  I-cache line address; low 5 bits ignored.
- ic_done  out  1  one-cycle completion pulse.
- ic_line  out  LINE_W  filled line; word k at bits [32k+31:32k].
- dc_req  in  1  D-cache request; held until dc_done.
- dc_we  in  1  1 = writeback, 0 = fill.
- dc_addr  in  ADDR_W  D-cache line address; low 5 bits ignored.
- dc_wline  in  LINE_W  writeback line.
- dc_done  out  1  one-cycle completion pulse.
- dc_line  out  LINE_W  filled line.
- mem_req  out  1  beat request.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  word address of the current beat.
- mem_wdata  out  WORD_W  write data.
- mem_ack  in  1  beat accepted (write) or rdata valid (read).
- mem_rdata  in  WORD_W  read data.
- busy  out  1  state != IDLE.

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-high.
- Reset values: state IDLE, beat 0, grant id DC, RR pointer = DC. All outputs 0, including both *_line outputs and the buffer.
- Reset mid-burst: abandons the transfer immediately with no done pulse. The memory side must tolerate the truncated burst.

State IDLE:
- Samples ic_req and dc_req only in IDLE.
- If either is asserted:
  - latch the grant id, line address[ADDR_W-1:5] and we (ic: we = 0);
  - on writeback, load dc_wline into the buffer;
  - beat <= 0; go to XFER.

State XFER:
- mem_req = 1, mem_we = latched we.
- mem_addr = {line_addr, beat[2:0], 2'b00}.
- mem_wdata = buffer word[beat].
- On mem_ack:
  - read: buffer word[beat] <= mem_rdata;
  - beat++.
- The ack on beat 7 moves the FSM to DONE; beat wraps to 0.
- mem_ack is ignored outside XFER.
- A requester dropping req mid-burst does not abort the burst.

State DONE:
- Asserts the granted requester's *_done for exactly one cycle.
- For a fill, copies the buffer to that requester's *_line on entry. It stays valid until that requester's next fill completes.
- dc_line is unchanged on a writeback.
- Next state is IDLE.

Requester rule:
- A requester clears req at the clock edge ending its done cycle, so IDLE does not re-grant it.

Latency:
- With mem_ack tied high, done asserts on cycle 10 after req is first sampled: 1 IDLE + 8 XFER + 1 DONE.
- Each mem_ack stall adds one cycle.

Simultaneous events:
- Both requests in IDLE are resolved by the arbiter (see Optional Feature).
- The loser is served next IDLE, with no loss.

Optional Feature:
- Macro: LINE_XFER_RR_ARB_EN.
- Defined: round-robin arbitration. A pointer records the last grant, and the other requester wins the next tie. The pointer resets to favour DC.
- Undefined: fixed priority, DC always wins ties. IC can starve under continuous DC traffic.

Decomposition:
- Package line_xfer_pkg:
  - xfer_state_t {IDLE, XFER, DONE};
  - req_id_t {REQ_DC, REQ_IC};
  - constants LINE_W, WORD_W, WORDS_PER_LINE, BEAT_W = 3, OFFSET_W = 5.
- One sub-module, line_arbiter:
  - two-requester grant logic, combinational grant plus RR pointer register;
  - the macro is confined there.

Test Plan:
- IC fill, ic_addr = 0x0000_1040, mem_ack always 1, mem_rdata = 0xA0 + beat:
  - mem_addr steps 0x1040 to 0x105C;
  - ic_done on cycle 10;
  - ic_line word k = 0xA0 + k.
- DC writeback, dc_wline word k = 0x1111_0000 + k, ack stalled 2 cycles on beat 3:
  - mem_we = 1 throughout;
  - mem_wdata word order 0..7, held stable during the stall;
  - dc_done on cycle 12;
  - dc_line unchanged.
- ic_req and dc_req rise in the same cycle:
  - fixed priority: DC then IC;
  - with LINE_XFER_RR_ARB_EN, two back-to-back ties are granted DC then IC, then IC then DC.
- rst asserted after the beat-4 ack:
  - mem_req, busy and *_done drop immediately;
  - after release, a new IC fill completes correctly.
- IC drops ic_req during beat 2: the burst still completes and ic_done pulses once.
